// File: rtl/microrisc_pkg.sv
// microrisc_pkg: shared register-file defaults and write-back port count.
package microrisc_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;
  localparam int NUM_WB     = 2;
  typedef enum logic [0:0] {
    WB0 = 1'b0,
    WB1 = 1'b1
  } wb_port_e;
  function automatic int nregs(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write bits, set on issue and cleared on write-back.
module rf_scoreboard
  import microrisc_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int NREGS    = nregs(ADDR_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_rd,
  input  logic [NUM_WB-1:0]        wb_we,
  input  logic [NUM_WB*ADDR_W-1:0] wb_addr,
  output logic [NREGS-1:0]         busy_vec
);
  logic [NREGS-1:0] busy_q, busy_d;
  // Issue is applied after the clears so a same-cycle issue keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NUM_WB; p++)
      if (wb_we[p]) busy_d[wb_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
    if (issue_valid) busy_d[issue_rd] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else busy_q <= busy_d;
  end
  assign busy_vec = busy_q;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/2W register file with write-back scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle write-back data and busy clears to the read ports.
module regfile_sb
  import microrisc_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int NREGS    = nregs(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              wb0_we,
  input  logic [ADDR_W-1:0] wb0_addr,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_we,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [DATA_W-1:0] wb1_data,
  output logic [NREGS-1:0]  busy_vec
);
  localparam logic ZR = ZERO_REG != 0;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] rs1_st, rs2_st;
  // wb1 is the later stage, so it is applied last and wins on address clashes.
  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    if (wb0_we) regs_d[wb0_addr] = wb0_data;
    if (wb1_we) regs_d[wb1_addr] = wb1_data;
    if (ZR) regs_d[0] = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    else regs_q <= regs_d;
  end
  assign rs1_st = (ZR && rs1_addr == '0) ? '0 : regs_q[rs1_addr];
  assign rs2_st = (ZR && rs2_addr == '0) ? '0 : regs_q[rs2_addr];
  rf_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .NREGS(NREGS)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .wb_we      ({wb1_we, wb0_we}),
    .wb_addr    ({wb1_addr, wb0_addr}),
    .busy_vec   (busy_vec)
  );
`ifdef REGFILE_SB_BYPASS_EN
  logic rs1_h0, rs1_h1, rs2_h0, rs2_h1;
  // Forwarding is suppressed in reset and for the hardwired zero register.
  assign rs1_h0 = !rst && wb0_we && wb0_addr == rs1_addr && !(ZR && rs1_addr == '0);
  assign rs1_h1 = !rst && wb1_we && wb1_addr == rs1_addr && !(ZR && rs1_addr == '0);
  assign rs2_h0 = !rst && wb0_we && wb0_addr == rs2_addr && !(ZR && rs2_addr == '0);
  assign rs2_h1 = !rst && wb1_we && wb1_addr == rs2_addr && !(ZR && rs2_addr == '0);
  assign rs1_data = rs1_h1 ? wb1_data : rs1_h0 ? wb0_data : rs1_st;
  assign rs2_data = rs2_h1 ? wb1_data : rs2_h0 ? wb0_data : rs2_st;
  assign rs1_busy = (rs1_h0 || rs1_h1) ? 1'b0 : busy_vec[rs1_addr];
  assign rs2_busy = (rs2_h0 || rs2_h1) ? 1'b0 : busy_vec[rs2_addr];
`else
  assign rs1_data = rs1_st;
  assign rs2_data = rs2_st;
  assign rs1_busy = busy_vec[rs1_addr];
  assign rs2_busy = busy_vec[rs2_addr];
`endif
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven check of regfile_sb reads, writes, scoreboard and reset.
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  rs1_addr = '0, rs2_addr = '0;
  logic [15:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  logic        issue_valid = 1'b0;
  logic [2:0]  issue_rd = '0;
  logic        wb0_we = 1'b0, wb1_we = 1'b0;
  logic [2:0]  wb0_addr = '0, wb1_addr = '0;
  logic [15:0] wb0_data = '0, wb1_data = '0;
  logic [7:0]  busy_vec;
  int n_cmp = 0;
  int n_bad = 0;

  regfile_sb dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .wb0_we(wb0_we), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_we(wb1_we), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [2:0]  ird;
    logic        w0;
    logic [2:0]  a0;
    logic [15:0] d0;
    logic        w1;
    logic [2:0]  a1;
    logic [15:0] d1;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        eb1;
    logic        eb2;
    logic [7:0]  ebv;
  } vec_t;

  vec_t v [17];

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0; wb0_we = 1'b0; wb1_we = 1'b0; rst = 1'b0;
  endtask

  initial begin
    //        rst iv ird w0 a0 d0       w1 a1 d1       r1 r2 e1       e2       eb1 eb2 ebv
    v[0]  = '{1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 3, 5, 16'h0000, 16'h0000, 0, 0, 8'h00};
    v[1]  = '{0, 0, 0, 1, 3, 16'hBEEF, 0, 0, 16'h0000, 3, 5, 16'hBEEF, 16'h0000, 0, 0, 8'h00};
    v[2]  = '{0, 0, 0, 1, 5, 16'h1111, 1, 5, 16'h2222, 5, 3, 16'h2222, 16'hBEEF, 0, 0, 8'h00};
    v[3]  = '{0, 1, 0, 1, 0, 16'hFFFF, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 8'h00};
    v[4]  = '{0, 1, 2, 0, 0, 16'h0000, 0, 0, 16'h0000, 2, 3, 16'h0000, 16'hBEEF, 1, 0, 8'h04};
    v[5]  = '{0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 2, 0, 16'h0000, 16'h0000, 1, 0, 8'h04};
    v[6]  = '{0, 0, 0, 1, 2, 16'h00AA, 0, 0, 16'h0000, 2, 5, 16'h00AA, 16'h2222, 0, 0, 8'h00};
    v[7]  = '{0, 1, 4, 0, 0, 16'h0000, 1, 4, 16'h0004, 4, 2, 16'h0004, 16'h00AA, 1, 0, 8'h10};
    v[8]  = '{0, 0, 0, 1, 4, 16'h0044, 0, 0, 16'h0000, 4, 4, 16'h0044, 16'h0044, 0, 0, 8'h00};
    v[9]  = '{0, 1, 2, 0, 0, 16'h0000, 0, 0, 16'h0000, 2, 3, 16'h00AA, 16'hBEEF, 1, 0, 8'h04};
    v[10] = '{0, 1, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 2, 3, 16'h00AA, 16'hBEEF, 1, 1, 8'h0C};
    v[11] = '{1, 1, 6, 1, 2, 16'h1234, 1, 3, 16'h4321, 2, 3, 16'h0000, 16'h0000, 0, 0, 8'h00};
    v[12] = '{0, 0, 0, 0, 0, 16'h0000, 1, 3, 16'h3333, 5, 3, 16'h0000, 16'h3333, 0, 0, 8'h00};
    v[13] = '{0, 1, 6, 0, 0, 16'h0000, 0, 0, 16'h0000, 6, 3, 16'h0000, 16'h3333, 1, 0, 8'h40};
    v[14] = '{0, 1, 6, 0, 0, 16'h0000, 0, 0, 16'h0000, 6, 2, 16'h0000, 16'h0000, 1, 0, 8'h40};
    v[15] = '{0, 0, 0, 0, 0, 16'h0000, 1, 6, 16'h6666, 6, 6, 16'h6666, 16'h6666, 0, 0, 8'h00};
    v[16] = '{0, 0, 0, 1, 7, 16'h7777, 1, 1, 16'h0101, 7, 1, 16'h7777, 16'h0101, 0, 0, 8'h00};

    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      rst = v[i].rst; issue_valid = v[i].iv; issue_rd = v[i].ird;
      wb0_we = v[i].w0; wb0_addr = v[i].a0; wb0_data = v[i].d0;
      wb1_we = v[i].w1; wb1_addr = v[i].a1; wb1_data = v[i].d1;
      rs1_addr = v[i].r1; rs2_addr = v[i].r2;
      @(posedge clk);
      #1 idle();
      #1;
      chk("rs1_data", i, rs1_data, v[i].e1);
      chk("rs2_data", i, rs2_data, v[i].e2);
      chk("rs1_busy", i, 16'(rs1_busy), 16'(v[i].eb1));
      chk("rs2_busy", i, 16'(rs2_busy), 16'(v[i].eb2));
      chk("busy_vec", i, 16'(busy_vec), 16'(v[i].ebv));
    end

    // Read path is combinational: change addresses with no clock edge.
    rs1_addr = 3'd7; rs2_addr = 3'd3;
    #1;
    chk("comb_rs1", 100, rs1_data, 16'h7777);
    chk("comb_rs2", 100, rs2_data, 16'h3333);

    // Write-back cycle observation: issue R5, then both ports write R5 with rs1/rs2 on R5.
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 3'd5;
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    rs1_addr = 3'd5; rs2_addr = 3'd5;
    wb0_we = 1'b1; wb0_addr = 3'd5; wb0_data = 16'h55AA;
    wb1_we = 1'b1; wb1_addr = 3'd5; wb1_data = 16'h5A5A;
    #1;
    chk("wbcyc_bv", 101, 16'(busy_vec), 16'h0020);
`ifdef REGFILE_SB_BYPASS_EN
    chk("wbcyc_rs1", 101, rs1_data, 16'h5A5A);
    chk("wbcyc_rs2", 101, rs2_data, 16'h5A5A);
    chk("wbcyc_b1", 101, 16'(rs1_busy), 16'h0000);
    chk("wbcyc_b2", 101, 16'(rs2_busy), 16'h0000);
`else
    chk("wbcyc_rs1", 101, rs1_data, 16'h0000);
    chk("wbcyc_rs2", 101, rs2_data, 16'h0000);
    chk("wbcyc_b1", 101, 16'(rs1_busy), 16'h0001);
    chk("wbcyc_b2", 101, 16'(rs2_busy), 16'h0001);
`endif
    @(posedge clk);
    #1 idle();
    #1;
    chk("after_rs1", 102, rs1_data, 16'h5A5A);
    chk("after_b1", 102, 16'(rs1_busy), 16'h0000);
    chk("after_bv", 102, 16'(busy_vec), 16'h0000);

    // Write to R0 is never visible, even in its own cycle.
    @(negedge clk);
    rs1_addr = 3'd0;
    wb1_we = 1'b1; wb1_addr = 3'd0; wb1_data = 16'hFFFF;
    #1;
    chk("r0_same", 103, rs1_data, 16'h0000);
    @(posedge clk);
    #1 idle();
    #1;
    chk("r0_after", 103, rs1_data, 16'h0000);
    chk("r0_bv", 103, 16'(busy_vec), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, register address width; NREGS = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports rs1_addr, rs2_addr  input  ADDR_W  read addresses.
REQ-007 SHALL have ports rs1_data, rs2_data  output  DATA_W  read data.
REQ-008 SHALL have ports rs1_busy, rs2_busy  output  1  source has a pending write.
REQ-009 SHALL have port issue_valid  input  1  instruction issued this cycle.
REQ-010 SHALL have port issue_rd  input  ADDR_W  destination of the issued instruction.
REQ-011 SHALL have ports wb0_we, wb1_we  input  1  write-back enables (wb1 is the later pipeline stage).
REQ-012 SHALL have ports wb0_addr, wb1_addr  input  ADDR_W, and wb0_data, wb1_data  input  DATA_W.
REQ-013 SHALL have port busy_vec  output  NREGS  registered scoreboard state.

Function
REQ-014 SHALL read combinationally, with zero-cycle latency from address to data.
REQ-015 SHALL write on the rising clk edge when wbN_we is high.
REQ-016 SHALL give wb1 priority over wb0 when both write the same address in one cycle.
REQ-017 SHALL, with ZERO_REG=1, return 0 on reads of address 0, ignore writes to it, and never set busy_vec[0].
REQ-018 SHALL set busy_vec[issue_rd] on the edge after issue_valid is high.
REQ-019 SHALL clear busy_vec[a] on the edge after any wbN_we writes address a.
REQ-020 SHALL let the set win when issue and write-back target the same register in one cycle, so busy stays 1.
REQ-021 SHALL drive rsN_busy = busy_vec[rsN_addr], unless it is cleared by a same-cycle write-back when bypass is compiled in.
REQ-022 SHALL treat issue to an already-busy register as legal: busy remains set and exactly one write-back clears it.

Reset
REQ-023 SHALL, on any clk edge with rst high, zero all registers and busy_vec, overriding same-cycle writes and issues.
REQ-024 SHALL, during reset, drive rs1_data and rs2_data as the register contents (0 after the first reset edge), rsN_busy 0 after the first reset edge, and busy_vec 0.
REQ-025 SHALL drop all pending writes when reset asserts mid-operation; later write-backs to those registers then store data normally.

Configuration
REQ-026 SHALL honour macro REGFILE_SB_BYPASS_EN.
REQ-027 SHALL, with REGFILE_SB_BYPASS_EN defined, forward same-cycle wbN data to a matching rsN_addr (wb1 over wb0) and deassert rsN_busy for it.
REQ-028 SHALL, without REGFILE_SB_BYPASS_EN, return the stored value and the registered busy bit, so the write becomes visible one cycle later.

Structure
REQ-029 SHALL take the default DATA_W/ADDR_W constants and the write-port count from the shared package microrisc_pkg.
REQ-030 SHALL place the scoreboard in sub-module rf_scoreboard, which takes issue and write-back inputs and outputs busy_vec.

Verification
REQ-031 SHALL check: reset, then write 0xBEEF to R3 via wb0 -> next cycle rs1_addr=3 reads 0xBEEF.
REQ-032 SHALL check: wb0 writes 0x1111 and wb1 writes 0x2222 to R5 in the same cycle -> R5 = 0x2222.
REQ-033 SHALL check: write 0xFFFF to R0 with ZERO_REG=1 -> reads return 0 and busy_vec[0] = 0.
REQ-034 SHALL check: issue R2, then wb0 R2 = 0x00AA two cycles later -> busy_vec[2] is 1 for 2 cycles, then 0; with bypass, rs1 reads 0x00AA and not busy in the write-back cycle.
REQ-035 SHALL check: issue R4 in the same cycle as wb1 writes R4 = 0x0004 -> busy_vec[4] = 1 and R4 = 0x0004.
REQ-036 SHALL check: rst high while busy_vec = 0x0C and wb0 writes R2 -> next cycle all registers 0 and busy_vec = 0.
